data_ram_lsu: RTL

DATA_RAM_LSU -- requirements
Module: data_ram_lsu

---
 rtl/data_ram_lsu.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/data_ram_lsu.sv
// rtl/data_ram_lsu.sv - word-organised data RAM with a RISC-V style byte/half/word load-store port
//
// Purpose: single-port data memory of 2**addrWidth 32-bit words. After reset,
// an INIT sweep zeroes every word. The block then accepts one load or store
// per cycle and returns a single-cycle response one cycle after accept.
//
// Ports:
//   clk         - clock, all state changes on the rising edge
//   clear       - synchronous active-high reset; restarts the zeroing sweep
//   req_valid   - request present
//   req_ready   - high only once the zeroing sweep has finished
//   req_we      - 1 = store, 0 = load
//   req_funct3  - RISC-V load/store funct3 (B/H/W/BU/HU)
//   req_addr    - byte address (addrWidth+2 bits)
//   req_wdata   - store data, LSB-aligned
//   rsp_valid   - one-cycle response pulse per accepted request
//   rsp_rdata   - extended load data; zero for stores, errors and idle
//   rsp_err     - misaligned access or illegal funct3
module data_ram_lsu #(
    parameter int width     = 32,
    parameter int addrWidth = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [addrWidth+1:0] req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err
);

    generate
        if (width != 32) begin : g_width_check
            $error("data_ram_lsu: only width = 32 is supported");
        end
    endgenerate

    localparam int depth = 2 ** addrWidth;

    typedef enum logic {INIT, READY} state_t;

    state_t               state;
    state_t               state_next;
    logic [addrWidth-1:0] cnt;
    logic [31:0]          mem [depth];

    logic                 accept;
    logic [addrWidth-1:0] word_idx;
    logic [1:0]           lane;
    logic                 err;
    logic [3:0]           byte_en;
    logic [31:0]          wdata_lanes;
    logic [31:0]          rd_word;
    logic [31:0]          rd_shifted;
    logic [31:0]          load_val;

    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [31:0]          rsp_rdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave INIT on the cycle the last word is zeroed
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (cnt == {addrWidth{1'b1}}) state_next = READY;
            READY:   state_next = READY;
            default: state_next = INIT;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state == READY);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign accept   = req_valid & req_ready;
    assign word_idx = req_addr[addrWidth+1:2];
    assign lane     = req_addr[1:0];

    // Access decode: legality, byte enables and lane-aligned store data
    always_comb begin
        err     = 1'b0;
        byte_en = 4'b0000;
        case (req_funct3)
            3'b000: byte_en = 4'b0001 << lane;
            3'b001: begin
                err     = lane[0];
                byte_en = 4'b0011 << lane;
            end
            3'b010: begin
                err     = |lane;
                byte_en = 4'b1111;
            end
            3'b100: err = req_we;
            3'b101: err = req_we | lane[0];
            default: err = 1'b1;
        endcase
    end

    assign wdata_lanes = req_wdata << {lane, 3'b000};

    // Loads see a store from the previous cycle because the store has
    // already landed in the array by the time the load is accepted.
    assign rd_word    = mem[word_idx];
    assign rd_shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        load_val = 32'h0;
        case (req_funct3)
            3'b000:  load_val = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  load_val = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'h0, rd_shifted[7:0]};
            3'b101:  load_val = {16'h0, rd_shifted[15:0]};
            default: load_val = 32'h0;
        endcase
    end

    // Memory array: zeroing sweep during INIT, byte-lane stores when READY
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (state == INIT) begin
                mem[cnt] <= 32'h0;
            end else if (accept && req_we && !err) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) begin
                        mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & err;
            rsp_rdata_q <= (accept && !req_we && !err) ? load_val : 32'h0;
        end
    end

    // A response still in flight when clear rises is suppressed immediately
    // rather than being shown for a cycle and then dropped.
    assign rsp_valid = rsp_valid_q & ~clear;
    assign rsp_err   = rsp_err_q & ~clear;
    assign rsp_rdata = clear ? 32'h0 : rsp_rdata_q;

endmodule
